// File: rtl/gol_pixel_renderer.sv
// Game-of-Life pixel renderer: maps raster position to a cell, reads cell RAM, outputs 3-stage aligned colour.
// Optional `GOL_GRIDLINES_EN draws 12'h444 grid lines on cell borders when zoom_q >= 2.
module gol_pixel_renderer #(
    parameter int          GRID_LOG2 = 6,
    parameter logic [11:0] ALIVE_RGB = 12'h0F0,
    parameter logic [11:0] DEAD_RGB  = 12'h000,
    parameter logic [11:0] OUT_RGB   = 12'h222
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic [9:0]             sx,
    input  logic [9:0]             sy,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   de_in,
    input  logic [2:0]             zoom,
    output logic [2*GRID_LOG2-1:0] cell_addr,
    input  logic                   cell_data,
    output logic [11:0]            rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   frame_done
);

    logic       frame_start;
    logic [2:0] zoom_q;
    logic [2:0] zoom_eff;
    logic [9:0] cell_x;
    logic [9:0] cell_y;
    logic       in_grid;
    logic       fd_hit;
    logic       fd_hit_q;

    // Stage 1 / stage 2 pipeline registers
    logic in_grid_1, de_1, hs_1, vs_1;
    logic in_grid_2, de_2, hs_2, vs_2;

    assign frame_start = (sx == 10'd0) && (sy == 10'd0);
    // The first pixel of a frame already renders with the newly latched zoom.
    assign zoom_eff    = frame_start ? zoom : zoom_q;
    assign cell_x      = sx >> zoom_eff;
    assign cell_y      = sy >> zoom_eff;
    assign in_grid     = ((cell_x >> GRID_LOG2) == 10'd0) && ((cell_y >> GRID_LOG2) == 10'd0);
    assign fd_hit      = (sx == 10'd0) && (sy == 10'd480);

`ifdef GOL_GRIDLINES_EN
    logic [9:0] gl_mask;
    logic       grid_line;
    logic       gl_1, gl_2;

    assign gl_mask   = (10'd1 << zoom_eff) - 10'd1;
    assign grid_line = (zoom_eff >= 3'd2) && (((sx & gl_mask) == 10'd0) || ((sy & gl_mask) == 10'd0));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            gl_1 <= 1'b0;
            gl_2 <= 1'b0;
        end else begin
            gl_1 <= grid_line;
            gl_2 <= gl_1;
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            zoom_q     <= 3'd0;
            cell_addr  <= '0;
            in_grid_1  <= 1'b0;
            de_1       <= 1'b0;
            hs_1       <= 1'b1;
            vs_1       <= 1'b1;
            in_grid_2  <= 1'b0;
            de_2       <= 1'b0;
            hs_2       <= 1'b1;
            vs_2       <= 1'b1;
            rgb        <= 12'h000;
            de         <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            fd_hit_q   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (frame_start)
                zoom_q <= zoom;

            // Stage 1: address out; holding it off-grid avoids wrapping onto visible cells.
            if (in_grid)
                cell_addr <= {cell_y[GRID_LOG2-1:0], cell_x[GRID_LOG2-1:0]};
            in_grid_1 <= in_grid;
            de_1      <= de_in;
            hs_1      <= hsync_in;
            vs_1      <= vsync_in;

            // Stage 2: cell_data from the RAM lines up with these registers.
            in_grid_2 <= in_grid_1;
            de_2      <= de_1;
            hs_2      <= hs_1;
            vs_2      <= vs_1;

            // Stage 3: colour decision
            de    <= de_2;
            hsync <= hs_2;
            vsync <= vs_2;
            if (!de_2)
                rgb <= 12'h000;
            else if (!in_grid_2)
                rgb <= OUT_RGB;
`ifdef GOL_GRIDLINES_EN
            else if (gl_2)
                rgb <= 12'h444;
`endif
            else
                rgb <= cell_data ? ALIVE_RGB : DEAD_RGB;

            // Edge-detect so a stalled raster cannot pulse twice in one frame.
            fd_hit_q   <= fd_hit;
            frame_done <= fd_hit && !fd_hit_q;
        end
    end

endmodule

// File: tb/tb_gol_pixel_renderer.sv
// Directed self-checking bench for gol_pixel_renderer with a registered-read cell RAM model.
module tb_gol_pixel_renderer;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sx = '0, sy = '0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, de_in = 1'b0;
    logic [2:0]  zoom = '0;
    logic [11:0] cell_addr;
    logic        cell_data = 1'b0;
    logic [11:0] rgb;
    logic        hsync, vsync, de, frame_done;

    logic ram [0:4095];

    int n_chk = 0;
    int n_pass = 0;

    gol_pixel_renderer dut (
        .clk_in(clk_in), .rst(rst), .sx(sx), .sy(sy),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .zoom(zoom),
        .cell_addr(cell_addr), .cell_data(cell_data),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de), .frame_done(frame_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cell_data <= ram[cell_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic d);
        sx       = 10'(x);
        sy       = 10'(y);
        de_in    = d;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
    endtask

    task automatic ram_fill(input logic v);
        for (int i = 0; i < 4096; i++) ram[i] = v;
    endtask

    // Drive one pixel, optionally check the address one edge later, check colour three edges later.
    task automatic pixel(input string tag, input int x, input int y, input logic d,
                         input logic [11:0] exp_rgb, input int exp_addr);
        drive(x, y, d);
        step();
        if (exp_addr >= 0) chk({tag, "_addr"}, 32'(cell_addr), 32'(exp_addr));
        step();
        step();
        chk({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        chk({tag, "_de"}, 32'(de), 32'(d));
    endtask

    task automatic frame_start(input logic [2:0] z);
        zoom = z;
        drive(0, 0, 1'b1);
        step();
    endtask

    logic h_hs [0:3];
    logic h_vs [0:3];
    logic h_de [0:3];

    initial begin
        int sync_err, blank_err, fd_cnt, fd_err, j;
        ram_fill(1'b0);

        // Reset held for 4 cycles with active syncs on the inputs
        rst = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b1; sx = 10'd0; sy = 10'd480;
        repeat (4) step();
        chk("rst_rgb", 32'(rgb), 32'h000);
        chk("rst_de", 32'(de), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_addr", 32'(cell_addr), 0);
        rst = 1'b0;
        drive(100, 100, 1'b0);
        step();

        // zoom=3, cell (2,1) alive; coordinates chosen off the zoom-3 border lines
        ram[12'h042] = 1'b1;
        frame_start(3'd3);
        pixel("z3_a", 17, 9, 1'b1, 12'h0F0, 12'h042);
        pixel("z3_b", 23, 15, 1'b1, 12'h0F0, 12'h042);
        pixel("z3_right", 25, 9, 1'b1, 12'h000, 12'h043);
        pixel("z3_left", 15, 9, 1'b1, 12'h000, 12'h041);
        pixel("z3_outgrid_hold", 600, 9, 1'b1, 12'h222, 12'h041);

        // Zoom change mid-frame has no effect until next frame start
        zoom = 3'd1;
        drive(100, 200, 1'b1);
        step();
        pixel("zchg_mid", 17, 9, 1'b1, 12'h0F0, 12'h042);
        frame_start(3'd1);
        pixel("zchg_new_dead", 17, 9, 1'b1, 12'h000, 12'h108);
        pixel("zchg_new_alive", 5, 3, 1'b1, 12'h0F0, 12'h042);

        // zoom=0: off-grid colour and blanking
        frame_start(3'd0);
        pixel("z0_outgrid", 100, 10, 1'b1, 12'h222, -1);
        pixel("z0_blank", 700, 10, 1'b0, 12'h000, -1);

        // Mid-frame reset flushes pipeline and clears zoom_q
        frame_start(3'd3);
        drive(17, 9, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        chk("mrst_rgb", 32'(rgb), 0);
        chk("mrst_de", 32'(de), 0);
        chk("mrst_addr", 32'(cell_addr), 0);
        rst = 1'b0;
        ram[12'h251] = 1'b1;
        pixel("mrst_zoom0", 17, 9, 1'b1, 12'h0F0, 12'h251);

        // zoom=2 with all cells alive: border pixel vs interior pixel
        ram_fill(1'b1);
        frame_start(3'd2);
`ifdef GOL_GRIDLINES_EN
        pixel("gl_border", 4, 1, 1'b1, 12'h444, 12'h001);
`else
        pixel("gl_border", 4, 1, 1'b1, 12'h0F0, 12'h001);
`endif
        pixel("gl_interior", 5, 1, 1'b1, 12'h0F0, 12'h001);

        // Raster sweep around vertical blanking: sync/de delay, blanking, frame_done
        sync_err = 0; blank_err = 0; fd_cnt = 0; fd_err = 0; j = 0;
        for (int y = 478; y <= 492; y++) begin
            for (int x = 0; x < 800; x++) begin
                sx       = 10'(x);
                sy       = 10'(y);
                de_in    = (x < 640) && (y < 480);
                hsync_in = !((x >= 656) && (x < 752));
                vsync_in = !((y == 490) || (y == 491));
                h_hs[j % 4] = hsync_in;
                h_vs[j % 4] = vsync_in;
                h_de[j % 4] = de_in;
                step();
                if (frame_done) fd_cnt++;
                if (frame_done !== ((x == 0) && (y == 480))) fd_err++;
                if (j >= 2) begin
                    if (hsync !== h_hs[(j - 2) % 4] || vsync !== h_vs[(j - 2) % 4] ||
                        de !== h_de[(j - 2) % 4]) sync_err++;
                end
                if (!de && rgb !== 12'h000) blank_err++;
                j++;
            end
        end
        chk("sweep_sync_align", 32'(sync_err), 0);
        chk("sweep_blank_rgb", 32'(blank_err), 0);
        chk("sweep_fd_count", 32'(fd_cnt), 1);
        chk("sweep_fd_timing", 32'(fd_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
